// File: rtl/membus_core_mem.sv
// Core-memory slave on the processor membus: answers one module select with
// read-restore, clear-write and read-pause-write cycles against a 36-bit word array.
module membus_core_mem #(
  parameter logic [3:0] SEL       = 4'd0,
  parameter int         ADDR_W    = 12,
  parameter int         T_ACCESS  = 4,
  parameter int         T_PULSE   = 2,
  parameter int         T_WIN     = 4,
  parameter int         T_RESTORE = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        membus_rq_cyc,
  input  logic        membus_rd_rq,
  input  logic        membus_wr_rq,
  input  logic [14:0] membus_ma,
  input  logic [3:0]  membus_sel,
  input  logic        membus_fmc_select,
  input  logic        membus_wr_rs,
  input  logic [35:0] membus_mb_in,
  output logic        membus_addr_ack,
  output logic        membus_rd_rs,
  output logic [35:0] membus_mb_out,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ACK       = 3'd1;
  localparam logic [2:0] RD_ACCESS = 3'd2;
  localparam logic [2:0] RD_RS     = 3'd3;
  localparam logic [2:0] WR_WAIT   = 3'd4;
  localparam logic [2:0] WR_ACC    = 3'd5;
  localparam logic [2:0] RESTORE   = 3'd6;

  localparam logic [7:0] ACK_LAST = 8'(T_PULSE - 1);
  localparam logic [7:0] ACC_LAST = 8'(T_ACCESS - T_PULSE - 1);
  localparam logic [7:0] RS_LAST  = 8'(T_PULSE - 1);
  localparam logic [7:0] WIN_LAST = 8'(T_WIN - 1);
  localparam logic [7:0] RST_LAST = 8'(T_RESTORE - 1);

  logic [2:0]        state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [35:0]       data_q;
  logic [35:0]       mem [0:(1<<ADDR_W)-1];
  logic              accept, commit, restore_wb, mem_we;
  logic [35:0]       mem_wd;
  logic [ADDR_W-1:0] ma_word;
  logic              unused_ma_hi;

  // Upper address bits alias onto the same array.
  assign ma_word      = membus_ma[ADDR_W-1:0];
  assign unused_ma_hi = ^membus_ma[14:ADDR_W];

  assign accept = membus_rq_cyc & (membus_rd_rq | membus_wr_rq) &
                  (membus_sel == SEL) & ~membus_fmc_select;

  assign commit = ((state == WR_WAIT) && membus_wr_rs && (T_WIN <= 1)) ||
                  ((state == WR_ACC) && (cnt == WIN_LAST));
  assign restore_wb = (state == RD_RS) && (cnt == RS_LAST) && !wr_q;
  assign mem_we     = reset && (commit || restore_wb);
  assign mem_wd     = commit ? (data_q | membus_mb_in) : data_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 8'd1;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (accept) state_nx = ACK;
      end
      ACK: if (cnt == ACK_LAST) begin
        cnt_nx   = '0;
        state_nx = rd_q ? ((T_ACCESS > T_PULSE) ? RD_ACCESS : RD_RS) : WR_WAIT;
      end
      RD_ACCESS: if (cnt == ACC_LAST) begin
        cnt_nx   = '0;
        state_nx = RD_RS;
      end
      RD_RS: if (cnt == RS_LAST) begin
        cnt_nx   = '0;
        state_nx = wr_q ? WR_WAIT : RESTORE;
      end
      WR_WAIT: begin
        cnt_nx = '0;
        if (membus_wr_rs) begin
          state_nx = (T_WIN <= 1) ? RESTORE : WR_ACC;
          cnt_nx   = (T_WIN <= 1) ? 8'd0 : 8'd1;
        end
      end
      WR_ACC: if (cnt == WIN_LAST) begin
        cnt_nx   = '0;
        state_nx = RESTORE;
      end
      RESTORE: if (cnt == RST_LAST) begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && accept) begin
        rd_q <= membus_rd_rq;
        wr_q <= membus_wr_rq;
      end
    end
  end

  // Data register: fetched word for reads, cleared and OR-accumulated for writes.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      addr_q <= ma_word;
      data_q <= membus_rd_rq ? mem[ma_word] : '0;
    end else if (state == RD_RS && cnt == RS_LAST && wr_q) begin
      data_q <= '0;
    end else if ((state == WR_WAIT && membus_wr_rs) || state == WR_ACC) begin
      data_q <= data_q | membus_mb_in;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wd;
  end

  assign membus_addr_ack = (state == ACK);
  assign membus_rd_rs    = (state == RD_RS);
  assign membus_mb_out   = (state == RD_RS) ? data_q : '0;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_membus_core_mem.sv
// Directed bench for membus_core_mem: read data is scoreboarded against a queue
// filled when each read is requested.
module tb_membus_core_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic        rq_cyc, rd_rq, wr_rq, fmc, wr_rs;
  logic [14:0] ma;
  logic [3:0]  sel;
  logic [35:0] mb_in;
  logic        addr_ack, rd_rs, busy;
  logic [35:0] mb_out;

  int passes = 0;
  int total  = 0;
  logic [35:0] sb [$];
  logic        rd_prev = 1'b0;

  membus_core_mem dut (
    .clk(clk), .reset(reset),
    .membus_rq_cyc(rq_cyc), .membus_rd_rq(rd_rq), .membus_wr_rq(wr_rq),
    .membus_ma(ma), .membus_sel(sel), .membus_fmc_select(fmc),
    .membus_wr_rs(wr_rs), .membus_mb_in(mb_in),
    .membus_addr_ack(addr_ack), .membus_rd_rs(rd_rs),
    .membus_mb_out(mb_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%o exp=%o", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller in the first cycle after acceptance (n+1).
  task automatic req(input logic [14:0] a, input logic r, input logic w,
                     input logic [3:0] s, input logic f);
    ma = a; rd_rq = r; wr_rq = w; sel = s; fmc = f; rq_cyc = 1'b1;
    cyc();
    rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; sel = 4'd0; fmc = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) cyc();
    chk("idle_timeout", {35'd0, busy}, 36'd0);
  endtask

  task automatic do_write(input logic [14:0] a, input logic [35:0] v);
    req(a, 1'b0, 1'b1, 4'd0, 1'b0);
    cyc(); cyc();
    wr_rs = 1'b1; mb_in = v;
    cyc();
    wr_rs = 1'b0; mb_in = '0;
    wait_idle();
  endtask

  task automatic do_read(input logic [14:0] a, input logic [35:0] exp);
    sb.push_back(exp);
    req(a, 1'b1, 1'b0, 4'd0, 1'b0);
    wait_idle();
  endtask

  // Scoreboard: every rd_rs rising edge must carry the oldest queued word.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rd_rs && !rd_prev) begin
        if (sb.size() == 0) chk("unexpected_rd_rs", {35'd0, rd_rs}, 36'd0);
        else chk("rd_data", mb_out, sb.pop_front());
      end
      if (!rd_rs) chk("mb_out_idle_zero", mb_out, 36'd0);
    end
    rd_prev <= rd_rs;
  end

  initial begin
    reset = 1'b0; rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; fmc = 1'b0;
    wr_rs = 1'b0; ma = '0; sel = 4'd0; mb_in = '0;
    repeat (3) cyc();
    chk("rst_ack",  {35'd0, addr_ack}, 36'd0);
    chk("rst_rdrs", {35'd0, rd_rs}, 36'd0);
    chk("rst_busy", {35'd0, busy}, 36'd0);
    chk("rst_mb",   mb_out, 36'd0);
    reset = 1'b1;
    cyc();

    do_write(15'o00100, 36'o123456654321);
    do_write(15'o00101, 36'o777000111222);

    // Detailed read timing on 0o100: cycle index k means n+k.
    sb.push_back(36'o123456654321);
    req(15'o00100, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("rd_ack_n%0d", k), {35'd0, addr_ack}, {35'd0, (k <= 2)});
      chk($sformatf("rd_rs_n%0d", k), {35'd0, rd_rs}, {35'd0, (k == 5 || k == 6)});
      chk($sformatf("rd_busy_n%0d", k), {35'd0, busy}, {35'd0, (k <= 12)});
      if (k == 5) chk("rd_mb_n5", mb_out, 36'o123456654321);
      cyc();
    end

    do_read(15'o00101, 36'o777000111222);

    // Requests for another module or a fast-memory cycle are ignored.
    ma = 15'o00100; rd_rq = 1'b0; wr_rq = 1'b1; sel = 4'd1; rq_cyc = 1'b1;
    repeat (3) begin
      cyc();
      chk("nosel_ack", {35'd0, addr_ack}, 36'd0);
      chk("nosel_busy", {35'd0, busy}, 36'd0);
    end
    sel = 4'd0; fmc = 1'b1;
    repeat (3) begin
      cyc();
      chk("fmc_ack", {35'd0, addr_ack}, 36'd0);
      chk("fmc_busy", {35'd0, busy}, 36'd0);
    end
    rq_cyc = 1'b0; wr_rq = 1'b0; fmc = 1'b0;
    cyc();
    do_read(15'o00100, 36'o123456654321);

    // Read-pause-write: old value returned, new value stored.
    sb.push_back(36'o123456654321);
    req(15'o00100, 1'b1, 1'b1, 4'd0, 1'b0);
    repeat (6) cyc();
    chk("rpw_wait_busy", {35'd0, busy}, 36'd1);
    wr_rs = 1'b1; mb_in = 36'o5;
    cyc();
    wr_rs = 1'b0; mb_in = '0;
    wait_idle();
    do_read(15'o00100, 36'o5);

    // Write data split across the accumulation window.
    req(15'o00102, 1'b0, 1'b1, 4'd0, 1'b0);
    cyc(); cyc();
    wr_rs = 1'b1; mb_in = 36'o700000000000;
    cyc();
    wr_rs = 1'b0; mb_in = 36'o000000000007;
    cyc();
    mb_in = '0;
    wait_idle();
    do_read(15'o00102, 36'o700000000007);

    // Reset during RD_ACCESS aborts immediately.
    req(15'o00101, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("abort_ack",  {35'd0, addr_ack}, 36'd0);
    chk("abort_rdrs", {35'd0, rd_rs}, 36'd0);
    chk("abort_busy", {35'd0, busy}, 36'd0);
    chk("abort_mb",   mb_out, 36'd0);
    cyc();
    do_read(15'o00101, 36'o777000111222);

    // Reset during WR_ACC: uncommitted write must not land.
    req(15'o00102, 1'b0, 1'b1, 4'd0, 1'b0);
    cyc(); cyc();
    wr_rs = 1'b1; mb_in = '1;
    cyc();
    wr_rs = 1'b0;
    reset = 1'b0;
    cyc();
    reset = 1'b1; mb_in = '0;
    chk("wabort_busy", {35'd0, busy}, 36'd0);
    cyc();
    do_read(15'o00102, 36'o700000000007);

    // A request held during RESTORE is accepted once IDLE returns.
    sb.push_back(36'o5);
    req(15'o00100, 1'b1, 1'b0, 4'd0, 1'b0);
    repeat (6) cyc();
    sb.push_back(36'o777000111222);
    ma = 15'o00101; rd_rq = 1'b1; rq_cyc = 1'b1;
    for (int k = 7; k <= 13; k++) begin
      chk($sformatf("hold_ack_n%0d", k), {35'd0, addr_ack}, 36'd0);
      chk($sformatf("hold_busy_n%0d", k), {35'd0, busy}, {35'd0, (k <= 12)});
      cyc();
    end
    chk("hold_ack_n14", {35'd0, addr_ack}, 36'd1);
    rq_cyc = 1'b0; rd_rq = 1'b0;
    wait_idle();

    cyc(); cyc();
    chk("sb_empty", 36'(sb.size()), 36'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
